// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module  : regfile_pkg
// Brief   : Shared sizing constants and scoreboard operation encoding for the
//           register file and its pending-write scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int C_DATA_W  = 32;
    localparam int C_ADDR_W  = 5;
    localparam int C_CNT_W   = 2;
    localparam int C_REG_NUM = 2 ** C_ADDR_W;

    // Per-register counter action resolved for one cycle.
    typedef enum logic [1:0] {
        SB_HOLD = 2'd0,
        SB_INC  = 2'd1,
        SB_DEC  = 2'd2
    } sb_op_e;

    // An issue and a retire that both hit one register cancel out.
    function automatic sb_op_e sb_resolve(input logic inc_hit, input logic dec_hit);
        sb_op_e op;
        op = SB_HOLD;
        if (inc_hit && !dec_hit) begin
            op = SB_INC;
        end else if (dec_hit && !inc_hit) begin
            op = SB_DEC;
        end
        return op;
    endfunction

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : regfile_scoreboard
// Brief   : Per-register pending-write counters with saturation, sticky error
//           flag and two busy lookups. Optional busy bypass under the
//           REGFILE_BYPASS_EN macro.
// Revision: 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = C_ADDR_W,
    parameter int CNT_W  = C_CNT_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inc_i,
    input  logic [ADDR_W-1:0] inc_dest_i,
    input  logic              dec_i,
    input  logic [ADDR_W-1:0] dec_dest_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic              busy1_o,
    output logic              busy2_o,
    output logic              err_o
);

    localparam int               NUM       = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    logic             w_inc;
    logic             w_dec;
    logic [CNT_W-1:0] w_cnt     [NUM];
    logic [CNT_W-1:0] w_cnt_nxt [NUM];
    logic [NUM-1:0]   w_ovf;
    logic [NUM-1:0]   w_unf;
    logic             r_err;

    assign w_inc = inc_i && (inc_dest_i != '0);
    assign w_dec = dec_i && (dec_dest_i != '0);

    generate
        for (genvar i = 0; i < NUM; i++) begin : g_slot
            if (i == 0) begin : g_zero
                assign w_cnt[i]     = '0;
                assign w_cnt_nxt[i] = '0;
                assign w_ovf[i]     = 1'b0;
                assign w_unf[i]     = 1'b0;
            end else begin : g_cnt
                logic [CNT_W-1:0] r_cnt;
                logic             w_inc_hit;
                logic             w_dec_hit;
                sb_op_e           w_op;

                assign w_inc_hit = w_inc && (inc_dest_i == ADDR_W'(i));
                assign w_dec_hit = w_dec && (dec_dest_i == ADDR_W'(i));
                assign w_op      = sb_resolve(w_inc_hit, w_dec_hit);
                assign w_ovf[i]  = (w_op == SB_INC) && (r_cnt == C_CNT_MAX);
                assign w_unf[i]  = (w_op == SB_DEC) && (r_cnt == '0);

                // Out-of-range steps hold the counter at its limit.
                assign w_cnt_nxt[i] = (w_op == SB_INC && !w_ovf[i]) ? r_cnt + CNT_W'(1) :
                                      (w_op == SB_DEC && !w_unf[i]) ? r_cnt - CNT_W'(1) :
                                      r_cnt;

                always_ff @(posedge clk or negedge resetn) begin
                    if (!resetn) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= w_cnt_nxt[i];
                    end
                end

                assign w_cnt[i] = r_cnt;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_err <= 1'b0;
        end else if ((|w_ovf) || (|w_unf)) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;

`ifdef REGFILE_BYPASS_EN
    // A retire that drains the counter this cycle already releases the reader.
    assign busy1_o = (w_cnt[raddr1_i] != '0) &&
                     !(w_dec && (dec_dest_i == raddr1_i) && (w_cnt_nxt[raddr1_i] == '0));
    assign busy2_o = (w_cnt[raddr2_i] != '0) &&
                     !(w_dec && (dec_dest_i == raddr2_i) && (w_cnt_nxt[raddr2_i] == '0));
`else
    assign busy1_o = (w_cnt[raddr1_i] != '0);
    assign busy2_o = (w_cnt[raddr2_i] != '0);
`endif

endmodule : regfile_scoreboard
`default_nettype wire

// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
// Module  : regfile
// Brief   : 2**ADDR_W x DATA_W register file, two combinational read ports,
//           one WB write port and a pending-write scoreboard. Defining
//           REGFILE_BYPASS_EN forwards the WB write to same-cycle reads.
// Revision: 1.0 - initial release
// ============================================================================
module regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W = C_DATA_W,
    parameter int ADDR_W = C_ADDR_W,
    parameter int CNT_W  = C_CNT_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] rf_raddr1_i,
    output logic [DATA_W-1:0] rf_rdata1_o,
    input  logic [ADDR_W-1:0] rf_raddr2_i,
    output logic [DATA_W-1:0] rf_rdata2_o,
    input  logic              rf_we_i,
    input  logic [ADDR_W-1:0] rf_wdest_i,
    input  logic [DATA_W-1:0] rf_wdata_i,
    input  logic              sb_issue_i,
    input  logic [ADDR_W-1:0] sb_issue_dest_i,
    output logic              sb_busy1_o,
    output logic              sb_busy2_o,
    output logic              sb_err_o
);

    localparam int NUM = 2 ** ADDR_W;

    logic [DATA_W-1:0] w_data [NUM];
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    generate
        for (genvar i = 0; i < NUM; i++) begin : g_reg
            if (i == 0) begin : g_zero
                assign w_data[i] = '0;
            end else begin : g_store
                logic [DATA_W-1:0] r_data;

                always_ff @(posedge clk or negedge resetn) begin
                    if (!resetn) begin
                        r_data <= '0;
                    end else if (rf_we_i && (rf_wdest_i == ADDR_W'(i))) begin
                        r_data <= rf_wdata_i;
                    end
                end

                assign w_data[i] = r_data;
            end
        end
    endgenerate

    assign w_rd1 = w_data[rf_raddr1_i];
    assign w_rd2 = w_data[rf_raddr2_i];

`ifdef REGFILE_BYPASS_EN
    logic w_byp1;
    logic w_byp2;

    // Gated by resetn so a write presented during reset cannot leak out.
    assign w_byp1 = resetn && rf_we_i && (rf_wdest_i != '0) && (rf_wdest_i == rf_raddr1_i);
    assign w_byp2 = resetn && rf_we_i && (rf_wdest_i != '0) && (rf_wdest_i == rf_raddr2_i);

    assign rf_rdata1_o = w_byp1 ? rf_wdata_i : w_rd1;
    assign rf_rdata2_o = w_byp2 ? rf_wdata_i : w_rd2;
`else
    assign rf_rdata1_o = w_rd1;
    assign rf_rdata2_o = w_rd2;
`endif

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_scoreboard (
        .clk        (clk),
        .resetn     (resetn),
        .inc_i      (sb_issue_i),
        .inc_dest_i (sb_issue_dest_i),
        .dec_i      (rf_we_i),
        .dec_dest_i (rf_wdest_i),
        .raddr1_i   (rf_raddr1_i),
        .raddr2_i   (rf_raddr2_i),
        .busy1_o    (sb_busy1_o),
        .busy2_o    (sb_busy2_o),
        .err_o      (sb_err_o)
    );

endmodule : regfile
`default_nettype wire

// File: tb/tb_regfile.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile
// Brief   : Directed vector table, asynchronous reset sequence and randomized
//           run against an array/counter reference model of regfile.
// Revision: 1.0 - initial release
// ============================================================================
module tb_regfile;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int CMAX = 3;

    logic        clk = 1'b0;
    logic        resetn;
    logic [4:0]  rf_raddr1_i, rf_raddr2_i, rf_wdest_i, sb_issue_dest_i;
    logic [31:0] rf_rdata1_o, rf_rdata2_o, rf_wdata_i;
    logic        rf_we_i, sb_issue_i;
    logic        sb_busy1_o, sb_busy2_o, sb_err_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile dut (
        .clk             (clk),
        .resetn          (resetn),
        .rf_raddr1_i     (rf_raddr1_i),
        .rf_rdata1_o     (rf_rdata1_o),
        .rf_raddr2_i     (rf_raddr2_i),
        .rf_rdata2_o     (rf_rdata2_o),
        .rf_we_i         (rf_we_i),
        .rf_wdest_i      (rf_wdest_i),
        .rf_wdata_i      (rf_wdata_i),
        .sb_issue_i      (sb_issue_i),
        .sb_issue_dest_i (sb_issue_dest_i),
        .sb_busy1_o      (sb_busy1_o),
        .sb_busy2_o      (sb_busy2_o),
        .sb_err_o        (sb_err_o)
    );

    typedef struct packed {
        logic        we;
        logic [4:0]  wd;
        logic [31:0] wdat;
        logic        iss;
        logic [4:0]  id;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        eb1;
        logic        eb2;
        logic        eerr;
    } vec_t;

    vec_t tbl[$];

    // Reference model: plain arrays, counters kept as signed ints and clamped.
    logic [31:0] m_reg [32];
    int          m_cnt [32];
    logic        m_err;

    function automatic vec_t mk(input logic we, input logic [4:0] wd, input logic [31:0] wdat,
                                input logic iss, input logic [4:0] id,
                                input logic [4:0] a1, input logic [4:0] a2,
                                input logic [31:0] e1, input logic [31:0] e2,
                                input logic eb1, input logic eb2, input logic eerr);
        vec_t v;
        v = '{we, wd, wdat, iss, id, a1, a2, e1, e2, eb1, eb2, eerr};
        return v;
    endfunction

    task automatic drive(input logic we, input logic [4:0] wd, input logic [31:0] wdat,
                         input logic iss, input logic [4:0] id,
                         input logic [4:0] a1, input logic [4:0] a2);
        rf_we_i = we; rf_wdest_i = wd; rf_wdata_i = wdat;
        sb_issue_i = iss; sb_issue_dest_i = id;
        rf_raddr1_i = a1; rf_raddr2_i = a2;
    endtask

    task automatic check(input string name, input logic [31:0] e1, input logic [31:0] e2,
                         input logic eb1, input logic eb2, input logic eerr);
        n_vec++;
        if (rf_rdata1_o !== e1 || rf_rdata2_o !== e2 || sb_busy1_o !== eb1 ||
            sb_busy2_o !== eb2 || sb_err_o !== eerr) begin
            n_err++;
            $display("FAIL %s: got rd1=%h rd2=%h busy1=%b busy2=%b err=%b, expected rd1=%h rd2=%h busy1=%b busy2=%b err=%b",
                     name, rf_rdata1_o, rf_rdata2_o, sb_busy1_o, sb_busy2_o, sb_err_o,
                     e1, e2, eb1, eb2, eerr);
        end
    endtask

    function automatic int m_next(input int r);
        int raw;
        raw = m_cnt[r] + ((sb_issue_i && sb_issue_dest_i == r) ? 1 : 0)
                       - ((rf_we_i && rf_wdest_i == r) ? 1 : 0);
        if (raw > CMAX) raw = CMAX;
        if (raw < 0) raw = 0;
        return raw;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (BYP && rf_we_i && rf_wdest_i == a) return rf_wdata_i;
        return m_reg[a];
    endfunction

    function automatic logic m_busy(input logic [4:0] a);
        if (a == 0 || m_cnt[a] == 0) return 1'b0;
        if (BYP && rf_we_i && rf_wdest_i == a && m_next(int'(a)) == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic m_clear();
        for (int r = 0; r < 32; r++) begin
            m_reg[r] = 32'h0;
            m_cnt[r] = 0;
        end
        m_err = 1'b0;
    endtask

    task automatic m_step();
        int raw;
        for (int r = 1; r < 32; r++) begin
            raw = m_cnt[r] + ((sb_issue_i && sb_issue_dest_i == r) ? 1 : 0)
                           - ((rf_we_i && rf_wdest_i == r) ? 1 : 0);
            if (raw > CMAX || raw < 0) m_err = 1'b1;
            m_cnt[r] = m_next(r);
        end
        if (rf_we_i && rf_wdest_i != 0) m_reg[rf_wdest_i] = rf_wdata_i;
    endtask

    task automatic pulse_reset();
        #2 resetn = 1'b0;
        #2 resetn = 1'b1;
        m_clear();
    endtask

    initial begin
        m_clear();
        resetn = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        // Reset state
        tbl.push_back(mk(0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 0, 0, 0));
        // Write r5 after marking it pending
        tbl.push_back(mk(0, 5'd0, 32'h0, 1, 5'd5, 5'd5, 5'd0, 32'h0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 5'd5, 5'd0,
                         BYP ? 32'hDEADBEEF : 32'h0, 32'h0, !BYP, 0, 0));
        tbl.push_back(mk(0, 5'd0, 32'h0, 0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 0, 0, 0));
        // Write to r0 is dropped and leaves the scoreboard alone
        tbl.push_back(mk(1, 5'd0, 32'h12345678, 0, 5'd0, 5'd0, 5'd5, 32'h0, 32'hDEADBEEF, 0, 0, 0));
        tbl.push_back(mk(0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 0, 0, 0));
        // Same-cycle read of r7 during its write
        tbl.push_back(mk(0, 5'd0, 32'h0, 1, 5'd7, 5'd7, 5'd0, 32'h0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(1, 5'd7, 32'hA5A5A5A5, 0, 5'd0, 5'd7, 5'd7,
                         BYP ? 32'hA5A5A5A5 : 32'h0, BYP ? 32'hA5A5A5A5 : 32'h0, !BYP, !BYP, 0));
        tbl.push_back(mk(0, 5'd0, 32'h0, 0, 5'd0, 5'd7, 5'd0, 32'hA5A5A5A5, 32'h0, 0, 0, 0));
        // Two issues of r3, then two retires
        tbl.push_back(mk(0, 5'd0, 32'h0, 1, 5'd3, 5'd3, 5'd0, 32'h0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(0, 5'd0, 32'h0, 1, 5'd3, 5'd3, 5'd0, 32'h0, 32'h0, 1, 0, 0));
        tbl.push_back(mk(1, 5'd3, 32'h33, 0, 5'd0, 5'd3, 5'd0, BYP ? 32'h33 : 32'h0, 32'h0, 1, 0, 0));
        tbl.push_back(mk(1, 5'd3, 32'h34, 0, 5'd0, 5'd3, 5'd0, BYP ? 32'h34 : 32'h33, 32'h0, !BYP, 0, 0));
        tbl.push_back(mk(0, 5'd0, 32'h0, 0, 5'd0, 5'd3, 5'd0, 32'h34, 32'h0, 0, 0, 0));
        // r9: issue+retire cancel, then overflow and saturation at 3
        tbl.push_back(mk(1, 5'd9, 32'h99, 1, 5'd9, 5'd9, 5'd0, BYP ? 32'h99 : 32'h0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(0, 5'd0, 32'h0, 1, 5'd9, 5'd9, 5'd0, 32'h99, 32'h0, 0, 0, 0));
        tbl.push_back(mk(0, 5'd0, 32'h0, 1, 5'd9, 5'd9, 5'd0, 32'h99, 32'h0, 1, 0, 0));
        tbl.push_back(mk(0, 5'd0, 32'h0, 1, 5'd9, 5'd9, 5'd0, 32'h99, 32'h0, 1, 0, 0));
        tbl.push_back(mk(0, 5'd0, 32'h0, 1, 5'd9, 5'd9, 5'd0, 32'h99, 32'h0, 1, 0, 0));
        tbl.push_back(mk(0, 5'd0, 32'h0, 0, 5'd0, 5'd9, 5'd0, 32'h99, 32'h0, 1, 0, 1));
        tbl.push_back(mk(1, 5'd9, 32'h9A, 0, 5'd0, 5'd9, 5'd9,
                         BYP ? 32'h9A : 32'h99, BYP ? 32'h9A : 32'h99, 1, 1, 1));
        tbl.push_back(mk(1, 5'd9, 32'h9B, 0, 5'd0, 5'd9, 5'd0, BYP ? 32'h9B : 32'h9A, 32'h0, 1, 0, 1));
        tbl.push_back(mk(1, 5'd9, 32'h9C, 0, 5'd0, 5'd9, 5'd0, BYP ? 32'h9C : 32'h9B, 32'h0, !BYP, 0, 1));
        tbl.push_back(mk(0, 5'd0, 32'h0, 0, 5'd0, 5'd9, 5'd0, 32'h9C, 32'h0, 0, 0, 1));
        // Load counters for the reset test
        tbl.push_back(mk(0, 5'd0, 32'h0, 1, 5'd10, 5'd9, 5'd10, 32'h9C, 32'h0, 0, 0, 1));
        tbl.push_back(mk(0, 5'd0, 32'h0, 1, 5'd11, 5'd11, 5'd10, 32'h0, 32'h0, 0, 1, 1));

        #3;
        check("reset_held", 32'h0, 32'h0, 0, 0, 0);
        @(posedge clk);
        #2 resetn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].we, tbl[i].wd, tbl[i].wdat, tbl[i].iss, tbl[i].id, tbl[i].a1, tbl[i].a2);
            #3;
            check($sformatf("table[%0d]", i), tbl[i].e1, tbl[i].e2, tbl[i].eb1, tbl[i].eb2, tbl[i].eerr);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset between edges with a write presented
        drive(1, 5'd9, 32'hFFFF0000, 0, 5'd0, 5'd9, 5'd10);
        #2 resetn = 1'b0;
        #1 check("async_reset_low", 32'h0, 32'h0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 5'd5, 5'd11);
        #1 resetn = 1'b1;
        #1 check("after_reset_release", 32'h0, 32'h0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 5'd3, 5'd10);
        @(posedge clk);
        #1 check("after_reset_edge", 32'h0, 32'h0, 0, 0, 0);
        m_clear();

        // Randomized run against the reference model
        for (int c = 0; c < 600; c++) begin
            if (c % 150 == 149) pulse_reset();
            drive($urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            #3;
            check($sformatf("random[%0d]", c), m_read(rf_raddr1_i), m_read(rf_raddr2_i),
                  m_busy(rf_raddr1_i), m_busy(rf_raddr2_i), m_err);
            @(posedge clk);
            m_step();
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_regfile
`default_nettype wire
